// File: rtl/color_sensor_stabilizer.sv
// Purpose : debounce edge/corner cube colour sensors after each motor move, then present latched colours with a stable level.
// Latency : SETTLE_CYCLES + (MATCH_COUNT-1)*SAMPLE_DIV + 1 clocks from motor_done at best, bounded by MAX_SAMPLES samples (then timeout).
// Backpress: none; color_sensor_stable is a level the consumer polls, cleared only by send_setup_moves or reset.
//
// Ports:
//   clock / reset                 system clock, asynchronous active-low reset
//   motor_done                    1-cycle pulse, move batch finished (honoured only while waiting for a move)
//   send_setup_moves              1-cycle pulse, new batch starting; returns to waiting from any state
//   edge_color_raw/corner_color_raw  raw 3-bit colour codes, asynchronous to clock
//   edge_color_sensor/corner_color_sensor  latched colours
//   color_sensor_stable           level, latched colours are valid
//   sensor_timeout                level, current stable window was forced by running out of samples
module color_sensor_stabilizer #(
    parameter int unsigned SETTLE_CYCLES = 500000,
    parameter int unsigned SAMPLE_DIV    = 1000,
    parameter int unsigned MATCH_COUNT   = 8,
    parameter int unsigned MAX_SAMPLES   = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       motor_done,
    input  logic       send_setup_moves,
    input  logic [2:0] edge_color_raw,
    input  logic [2:0] corner_color_raw,
    output logic [2:0] edge_color_sensor,
    output logic [2:0] corner_color_sensor,
    output logic       color_sensor_stable,
    output logic       sensor_timeout
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned DIV_W = $clog2(SAMPLE_DIV + 1);
    localparam int unsigned MAT_W = $clog2(MATCH_COUNT + 1);
    localparam int unsigned SMP_W = $clog2(MAX_SAMPLES + 1);

    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [MAT_W-1:0] MATCH_TGT   = MAT_W'(MATCH_COUNT);
    localparam logic [SMP_W-1:0] SAMPLE_TGT  = SMP_W'(MAX_SAMPLES);

    localparam logic [2:0] COLOR_NULL = 3'd7;

    typedef enum logic [1:0] {
        ST_WAIT_MOVE = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_SAMPLE    = 2'd2,
        ST_STABLE    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [MAT_W-1:0] match_cnt_q, match_cnt_d;
    logic [SMP_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [2:0]       cand_edge_q, cand_edge_d;
    logic [2:0]       cand_corner_q, cand_corner_d;
    logic [2:0]       edge_out_q, edge_out_d;
    logic [2:0]       corner_out_q, corner_out_d;
    logic             timeout_q, timeout_d;

    // Two-flop synchronizers for the asynchronous sensor buses.
    logic [2:0] edge_s1_q, edge_s2_q;
    logic [2:0] corner_s1_q, corner_s2_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            edge_s1_q   <= COLOR_NULL;
            edge_s2_q   <= COLOR_NULL;
            corner_s1_q <= COLOR_NULL;
            corner_s2_q <= COLOR_NULL;
        end else begin
            edge_s1_q   <= edge_color_raw;
            edge_s2_q   <= edge_s1_q;
            corner_s1_q <= corner_color_raw;
            corner_s2_q <= corner_s1_q;
        end
    end

    // Codes 6 and 7 both mean "no colour seen".
    function automatic logic is_null(input logic [2:0] c);
        return (c == 3'd6) || (c == 3'd7);
    endfunction

    logic             pair_null;
    logic             pair_match;
    logic [MAT_W-1:0] match_new;
    logic [SMP_W-1:0] samp_new;
    logic             take_sample;

    // Results of a sample taken this cycle; only committed when take_sample is set.
    always_comb begin
        pair_null  = is_null(edge_s2_q) || is_null(corner_s2_q);
        pair_match = (edge_s2_q == cand_edge_q) && (corner_s2_q == cand_corner_q) && !pair_null;

        if (pair_match) begin
            match_new = (match_cnt_q == MATCH_TGT) ? match_cnt_q : match_cnt_q + 1'b1;
        end else begin
            match_new = pair_null ? '0 : MAT_W'(1);
        end

        samp_new = (samp_cnt_q == SAMPLE_TGT) ? samp_cnt_q : samp_cnt_q + 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        div_cnt_d     = div_cnt_q;
        match_cnt_d   = match_cnt_q;
        samp_cnt_d    = samp_cnt_q;
        cand_edge_d   = cand_edge_q;
        cand_corner_d = cand_corner_q;
        edge_out_d    = edge_out_q;
        corner_out_d  = corner_out_q;
        timeout_d     = timeout_q;
        take_sample   = 1'b0;

        case (state_q)
            ST_WAIT_MOVE: begin
                if (motor_done) begin
                    state_d       = ST_SETTLE;
                    settle_cnt_d  = '0;
                    div_cnt_d     = '0;
                    match_cnt_d   = '0;
                    samp_cnt_d    = '0;
                    cand_edge_d   = COLOR_NULL;
                    cand_corner_d = COLOR_NULL;
                end
            end
            ST_SETTLE: begin
                // The last settle clock doubles as the first sample strobe.
                if (settle_cnt_q == SETTLE_LAST) begin
                    take_sample = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (div_cnt_q == DIV_LAST) begin
                    take_sample = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            ST_STABLE: begin
                // Outputs held; motor_done deliberately ignored here.
            end
            default: begin
                state_d = ST_WAIT_MOVE;
            end
        endcase

        if (take_sample) begin
            state_d       = ST_SAMPLE;
            div_cnt_d     = '0;
            cand_edge_d   = edge_s2_q;
            cand_corner_d = corner_s2_q;
            match_cnt_d   = match_new;
            samp_cnt_d    = samp_new;
            // Match wins over timeout when both land on the same strobe.
            if (match_new == MATCH_TGT) begin
                state_d      = ST_STABLE;
                edge_out_d   = edge_s2_q;
                corner_out_d = corner_s2_q;
                timeout_d    = 1'b0;
            end else if (samp_new == SAMPLE_TGT) begin
                state_d      = ST_STABLE;
                edge_out_d   = edge_s2_q;
                corner_out_d = corner_s2_q;
                timeout_d    = 1'b1;
            end
        end

        // A new move batch aborts whatever is in progress; colours keep their last values.
        if (send_setup_moves) begin
            state_d      = ST_WAIT_MOVE;
            settle_cnt_d = '0;
            div_cnt_d    = '0;
            match_cnt_d  = '0;
            samp_cnt_d   = '0;
            timeout_d    = 1'b0;
            edge_out_d   = edge_out_q;
            corner_out_d = corner_out_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_WAIT_MOVE;
            settle_cnt_q  <= '0;
            div_cnt_q     <= '0;
            match_cnt_q   <= '0;
            samp_cnt_q    <= '0;
            cand_edge_q   <= COLOR_NULL;
            cand_corner_q <= COLOR_NULL;
            edge_out_q    <= COLOR_NULL;
            corner_out_q  <= COLOR_NULL;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            div_cnt_q     <= div_cnt_d;
            match_cnt_q   <= match_cnt_d;
            samp_cnt_q    <= samp_cnt_d;
            cand_edge_q   <= cand_edge_d;
            cand_corner_q <= cand_corner_d;
            edge_out_q    <= edge_out_d;
            corner_out_q  <= corner_out_d;
            timeout_q     <= timeout_d;
        end
    end

    assign edge_color_sensor   = edge_out_q;
    assign corner_color_sensor = corner_out_q;
    assign color_sensor_stable = (state_q == ST_STABLE);
    assign sensor_timeout      = timeout_q;

endmodule

// File: doc/color_sensor_stabilizer.md
# color_sensor_stabilizer

Upstream conditioning stage between the two raw cube color sensors (edge, corner) and the state-determination FSM. After each motor move completes, it waits a mechanical settle time, then requires a run of identical, non-NULL color samples from both sensors. It then presents latched colors with a `color_sensor_stable` level that the determination FSM polls in its IDLE states. If the colors never agree within a bounded number of samples, it still releases the FSM, forwards the last colors, and flags a timeout.

## Interface

Parameters:
- `SETTLE_CYCLES`, 500000: clocks waited after `motor_done` before the first sample (≥1).
- `SAMPLE_DIV`, 1000: clocks between consecutive samples (≥1).
- `MATCH_COUNT`, 8: consecutive identical samples required (≥1).
- `MAX_SAMPLES`, 64: samples taken before timeout (≥ `MATCH_COUNT`).

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `motor_done` in 1: one-cycle pulse from the motor sequencer; requested moves finished.
- `send_setup_moves` in 1: one-cycle pulse from the determination FSM; a new move batch is starting.
- `edge_color_raw` in 3: edge sensor color code, asynchronous to `clock`.
- `corner_color_raw` in 3: corner sensor color code, asynchronous to `clock`.
- `edge_color_sensor` out 3: latched edge color.
- `corner_color_sensor` out 3: latched corner color.
- `color_sensor_stable` out 1: level; outputs are valid for sampling.
- `sensor_timeout` out 1: level; the current stable window was forced by timeout.

## Operation

Color codes:
- 0 W, 1 O, 2 G, 3 Red, 4 Blue, 5 Y, 7 NULL.
- Code 6 is treated as NULL.

Input synchronizer:
- Each raw bus passes through a 2-flop synchronizer.
- Every comparison uses the synchronized values.

States:
- WAIT_MOVE (reset state)
  - `color_sensor_stable`=0.
  - On `motor_done` → SETTLE; settle counter loads 0.
- SETTLE
  - Counter increments each clock.
  - At count `SETTLE_CYCLES-1` → SAMPLE, taking sample 1 that same cycle.
- SAMPLE
  - A sample strobe fires on entry, then every `SAMPLE_DIV` clocks.
  - On each strobe, the pair {edge, corner} is sampled and the sample count increments.
  - If the pair equals the held candidate and neither color is NULL, match count increments.
  - Otherwise the candidate becomes the pair, and match count becomes 1 if neither is NULL, else 0.
  - When match count reaches `MATCH_COUNT` → STABLE; outputs load the candidate and `sensor_timeout`=0.
  - Otherwise, when the sample count reaches `MAX_SAMPLES` → STABLE; outputs load the latest pair and `sensor_timeout`=1.
  - The match check has priority over the timeout check on the same strobe.
- STABLE
  - `color_sensor_stable`=1; outputs are held.
  - `motor_done` is ignored.
  - On `send_setup_moves` → WAIT_MOVE.

Global rules:
- `send_setup_moves` in any state forces WAIT_MOVE next cycle and clears stable, timeout, and all counters. Color outputs keep their last values.
- If `send_setup_moves` and `motor_done` are asserted in the same cycle, `send_setup_moves` wins: go to WAIT_MOVE and drop `motor_done`.
- `motor_done` outside WAIT_MOVE is ignored; settling is not restarted.

Widths:
- Counters are `$clog2(param+1)` bits and never wrap, because they are compared for equality before overflow.
- Match and sample counters saturate at their limits.

Reset values:
- State WAIT_MOVE.
- `edge_color_sensor`=`corner_color_sensor`=7.
- `color_sensor_stable`=0, `sensor_timeout`=0.
- Candidate=7/7; all counters 0; synchronizer flops 7.

Reset behavior:
- Reset asserted mid-operation clears everything asynchronously.
- After reset release, the block requires a fresh `motor_done`.

## Timing

- `motor_done` high at edge t0: SETTLE active from t0+1.
- Sample k fires at t0+`SETTLE_CYCLES`+(k−1)·`SAMPLE_DIV`.
- Best-case `color_sensor_stable` rise is at t0+`SETTLE_CYCLES`+(`MATCH_COUNT`−1)·`SAMPLE_DIV`+1.
- Timeout rise is at t0+`SETTLE_CYCLES`+(`MAX_SAMPLES`−1)·`SAMPLE_DIV`+1.
- Color outputs change in the same cycle `color_sensor_stable` rises and are constant while it is high.
- `send_setup_moves` at edge t1: `color_sensor_stable`=0 at t1+1.
- Raw-to-sample latency is 2 clocks (synchronizer).

## Test plan

Bench parameters: `SETTLE_CYCLES`=4, `SAMPLE_DIV`=2, `MATCH_COUNT`=3, `MAX_SAMPLES`=6.

1. Raw edge=2, corner=5 held steady; `motor_done` at t0 → `color_sensor_stable` rises at t0+9 with outputs 2/5 and `sensor_timeout`=0.
2. Edge raw reads 2,3,3,3 at samples 1–4 → rise one `SAMPLE_DIV` later than scenario 1, at t0+11, with edge output 3.
3. Corner raw stuck at 7 → no match; at t0+15 `color_sensor_stable`=1, `sensor_timeout`=1, corner output 7.
4. `send_setup_moves` during STABLE → `color_sensor_stable`=0 next cycle, outputs hold; a following `motor_done` restarts and yields the new colors at t0'+9.
5. `send_setup_moves` and `motor_done` in the same cycle, and `motor_done` during SETTLE → block stays in or returns to WAIT_MOVE; the second `motor_done` does not shift sample timing.
6. `reset` driven low mid-SAMPLE → outputs immediately 7/7, `color_sensor_stable`=0; after release, nothing happens until `motor_done`.
